// File: rtl/plot_receiver_pkg.sv
// Shared widths, screen geometry and the buffered plot-entry record.
package plot_receiver_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned DROP_W   = 8;

    // One framebuffer write waiting in the FIFO.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } plot_entry_t;

    // Linear framebuffer address y*160 + x, built from shifts; max 19199 fits ADDR_W.
    function automatic logic [ADDR_W-1:0] plot_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
        return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot entries; a push into a full FIFO is accepted when a pop happens in the same cycle.
module plot_fifo
    import plot_receiver_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  plot_entry_t wdata_i,
    output plot_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    plot_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               pop_ok;
    logic               push_ok;

    assign pop_ok  = pop_i & ~empty_q;
    assign push_ok = push_i & (~full_q | pop_ok);

    // Pointer, occupancy and flag next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Control registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/plot_receiver.sv
// Captures plot strobes, converts them to framebuffer addresses and buffers them for the memory port.
module plot_receiver
    import plot_receiver_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SCREEN_W   = plot_receiver_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H   = plot_receiver_pkg::SCREEN_H
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOR_W-1:0]  color_in,
    input  logic                writeEn,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOR_W-1:0]  mem_data,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic                busy,
    output logic                overflow,
    output logic [DROP_W-1:0]   dropped_count
);

    logic               cap_valid_q, cap_valid_d;
    logic [X_W-1:0]     cap_x_q;
    logic [Y_W-1:0]     cap_y_q;
    logic [COLOR_W-1:0] cap_color_q;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

    plot_entry_t        push_entry;
    plot_entry_t        head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;

    // Only in-range strobes become valid captures.
    assign cap_valid_d = writeEn
                       && (32'(x_in) < SCREEN_W)
                       && (32'(y_in) < SCREEN_H);

    // Capture stage: raw coordinates every cycle, validity cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid_q <= 1'b0;
            cap_x_q     <= '0;
            cap_y_q     <= '0;
            cap_color_q <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_x_q     <= x_in;
            cap_y_q     <= y_in;
            cap_color_q <= color_in;
        end
    end

    assign push_entry.addr  = plot_addr(cap_x_q, cap_y_q);
    assign push_entry.color = cap_color_q;

    assign pop  = ~fifo_empty & mem_ready;
    assign drop = cap_valid_q & fifo_full & ~pop;

    plot_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cap_valid_q),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sticky overflow flag and saturating drop counter next-state.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    // Overflow bookkeeping registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head is shown only while an entry is presented, so an idle port reads as zero.
    assign mem_we        = ~fifo_empty;
    assign mem_addr      = mem_we ? head_entry.addr  : '0;
    assign mem_data      = mem_we ? head_entry.color : '0;
    assign busy          = cap_valid_q | ~fifo_empty;
    assign overflow      = overflow_q;
    assign dropped_count = drop_cnt_q;

endmodule

// File: tb/tb_plot_receiver.sv
// Directed and random stimulus for plot_receiver against a queue-based behavioural model.
module tb_plot_receiver;

    localparam int DEPTH = 8;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [7:0]  x_in      = '0;
    logic [6:0]  y_in      = '0;
    logic [2:0]  color_in  = '0;
    logic        writeEn   = 1'b0;
    logic        mem_ready = 1'b0;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        busy;
    logic        overflow;
    logic [7:0]  dropped_count;

    int n_checks = 0;
    int n_fail   = 0;

    plot_receiver #(
        .FIFO_DEPTH (DEPTH),
        .SCREEN_W   (160),
        .SCREEN_H   (120)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .x_in          (x_in),
        .y_in          (y_in),
        .color_in      (color_in),
        .writeEn       (writeEn),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_we        (mem_we),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .overflow      (overflow),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending capture plus a queue of buffered writes.
    int  q_addr[$];
    int  q_col[$];
    bit  cap_pend  = 0;
    int  cap_addr  = 0;
    int  cap_col   = 0;
    bit  m_ovf     = 0;
    int  m_drops   = 0;
    bit  live      = 0;

    always @(posedge clk) begin
        if (reset) begin
            q_addr.delete();
            q_col.delete();
            cap_pend = 0;
            m_ovf    = 0;
            m_drops  = 0;
            live     = 1;
        end else begin
            if (q_addr.size() != 0 && mem_ready) begin
                void'(q_addr.pop_front());
                void'(q_col.pop_front());
            end
            if (cap_pend) begin
                if (q_addr.size() < DEPTH) begin
                    q_addr.push_back(cap_addr);
                    q_col.push_back(cap_col);
                end else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            cap_pend = writeEn && (int'(x_in) < 160) && (int'(y_in) < 120);
            cap_addr = int'(y_in) * 160 + int'(x_in);
            cap_col  = int'(color_in);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (live) begin
            check("mem_we", 32'(mem_we), 32'(q_addr.size() != 0));
            if (q_addr.size() != 0) begin
                check("mem_addr", 32'(mem_addr), q_addr[0]);
                check("mem_data", 32'(mem_data), q_col[0]);
            end
            check("busy", 32'(busy), 32'(cap_pend || q_addr.size() != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("dropped_count", 32'(dropped_count), m_drops);
        end
    end

    // Drive one cycle of inputs, return at the following falling edge.
    task automatic cyc(input logic rst, input logic we, input logic [7:0] x,
                       input logic [6:0] y, input logic [2:0] c, input logic rdy);
        reset     = rst;
        writeEn   = we;
        x_in      = x;
        y_in      = y;
        color_in  = c;
        mem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(mem_we),        0);
        check({tag, "_addr"},  32'(mem_addr),      0);
        check({tag, "_data"},  32'(mem_data),      0);
        check({tag, "_busy"},  32'(busy),          0);
        check({tag, "_ovf"},   32'(overflow),      0);
        check({tag, "_drops"}, 32'(dropped_count), 0);
    endtask

    int n_we;

    initial begin
        // Reset with writeEn high: must be ignored.
        cyc(1, 1, 8'd5, 7'd5, 3'd1, 1);
        cyc(1, 0, 0, 0, 0, 1);
        check_all_zero("rst");

        // Single plot x=3,y=2,color=5: mem_we two cycles later, idle one after.
        cyc(0, 1, 8'd3, 7'd2, 3'd5, 1);
        check("single_busy_n1", 32'(busy), 1);
        check("single_we_n1", 32'(mem_we), 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("single_we_n2", 32'(mem_we), 1);
        check("single_addr", 32'(mem_addr), 323);
        check("single_data", 32'(mem_data), 5);
        cyc(0, 0, 0, 0, 0, 1);
        check("single_we_n3", 32'(mem_we), 0);
        check("single_busy_n3", 32'(busy), 0);

        // Corner address and out-of-range discards.
        cyc(0, 1, 8'd159, 7'd119, 3'd2, 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("corner_addr", 32'(mem_addr), 19199);
        check("corner_data", 32'(mem_data), 2);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 8'd160, 7'd0, 3'd7, 1);
        check("oor_x_busy", 32'(busy), 0);
        cyc(0, 1, 8'd0, 7'd120, 3'd7, 1);
        check("oor_y_busy", 32'(busy), 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("oor_we", 32'(mem_we), 0);
        check("oor_ovf", 32'(overflow), 0);
        check("oor_drops", 32'(dropped_count), 0);

        // Twelve plots into a stalled port: eight kept, four dropped, then in-order drain.
        for (int i = 0; i < 12; i++) cyc(0, 1, 8'(i), 7'd1, 3'(i % 8), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("ovf12_drops", 32'(dropped_count), 4);
        check("ovf12_ovf", 32'(overflow), 1);
        for (int k = 0; k < 8; k++) begin
            check("ovf12_we", 32'(mem_we), 1);
            check("ovf12_addr", 32'(mem_addr), 32'(160 + k));
            check("ovf12_data", 32'(mem_data), 32'(k % 8));
            cyc(0, 0, 0, 0, 0, 1);
        end
        check("ovf12_empty", 32'(mem_we), 0);

        // Full FIFO: push and pop in the same cycle keeps eight entries, no drop.
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'(i), 7'd2, 3'd3, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 8'd50, 7'd3, 3'd6, 0);
        check("full_head", 32'(mem_addr), 320);
        cyc(0, 0, 0, 0, 0, 1);
        check("full_pp_drops", 32'(dropped_count), 4);
        check("full_pp_head", 32'(mem_addr), 321);
        n_we = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem_we) n_we++;
            cyc(0, 0, 0, 0, 0, 1);
        end
        check("full_pp_occupancy", 32'(n_we), 8);

        // 300 drops saturate the counter.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 308; i++) cyc(0, 1, 8'(i % 160), 7'd0, 3'd1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("sat_drops", 32'(dropped_count), 255);
        check("sat_ovf", 32'(overflow), 1);

        // Reset mid-drain with five pending plots.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'(i), 7'd4, 3'd1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("pend_we", 32'(mem_we), 1);
        cyc(1, 1, 8'd9, 7'd9, 3'd1, 1);
        check_all_zero("mid_rst");
        cyc(0, 1, 8'd7, 7'd7, 3'd3, 1);
        check("post_rst_we", 32'(mem_we), 0);
        check("post_rst_busy", 32'(busy), 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("post_rst_addr", 32'(mem_addr), 1127);
        check("post_rst_data", 32'(mem_data), 3);
        cyc(0, 0, 0, 0, 0, 1);
        check("post_rst_idle", 32'(mem_we), 0);

        // Random traffic including out-of-range coordinates.
        for (int i = 0; i < 10000; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 170)),
                7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1);
        check("rand_busy", 32'(busy), 0);
        check("rand_we", 32'(mem_we), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_receiver.md
PLOT_RECEIVER -- requirements
Module: plot_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of buffered plot commands (power of 2, >= 2).
REQ-002 Parameter SCREEN_W, default 160, pixel columns.
REQ-003 Parameter SCREEN_H, default 120, pixel rows.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 x_in  input  8  plot x coordinate from the drawing engine.
REQ-007 y_in  input  7  plot y coordinate.
REQ-008 color_in  input  3  plot color (000 = erase/black).
REQ-009 writeEn  input  1  plot strobe, one pixel per cycle while high.
REQ-010 mem_addr  output  15  framebuffer word address, y*SCREEN_W + x.
REQ-011 mem_data  output  3  framebuffer write data.
REQ-012 mem_we  output  1  write request; high whenever a buffered entry is presented.
REQ-013 mem_ready  input  1  framebuffer accepts the presented write this cycle.
REQ-014 busy  output  1  high while any accepted plot is not yet written (capture stage or FIFO non-empty).
REQ-015 overflow  output  1  sticky; set when a valid plot is dropped for lack of space.
REQ-016 dropped_count  output  8  number of plots dropped for overflow, saturating at 255.

Function
REQ-017 Capture stage SHALL register x_in, y_in, color_in, writeEn every cycle; a captured plot is valid only if writeEn=1, x_in < SCREEN_W, y_in < SCREEN_H.
REQ-018 Out-of-range plots SHALL be discarded silently: no FIFO push, no overflow, no counter change.
REQ-019 Address SHALL be computed from the captured values as (y<<7)+(y<<5)+x in 15 bits, i.e. max 19199, no wrap.
REQ-020 A valid captured plot SHALL be pushed into the FIFO as {addr, color} on the cycle after capture.
REQ-021 mem_we SHALL equal FIFO non-empty; mem_addr/mem_data SHALL show the FIFO head, held stable until popped.
REQ-022 Pop SHALL occur on any cycle with mem_we=1 and mem_ready=1; order of writes SHALL equal order of plots.
REQ-023 Latency: writeEn at cycle N with empty FIFO and mem_ready=1 SHALL yield mem_we=1 at cycle N+2 with the matching address.
REQ-024 Throughput: with mem_ready held high, one plot per cycle SHALL be sustained with no drops.
REQ-025 Push when full with no pop in the same cycle SHALL drop the new plot, set overflow, increment dropped_count (saturate at 255).
REQ-026 Simultaneous push and pop when full SHALL succeed: the head leaves, the new entry enters, occupancy unchanged, no drop.
REQ-027 Simultaneous push and pop when exhausting to empty SHALL leave occupancy unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 overflow and dropped_count SHALL clear only on reset.

Reset
REQ-029 While reset=1 at a clock edge: FIFO flushed, capture stage invalidated, mem_we=0, mem_addr=0, mem_data=0, busy=0, overflow=0, dropped_count=0.
REQ-030 Reset asserted mid-drain SHALL discard all pending plots; no mem_we in the cycle after reset is sampled.
REQ-031 writeEn high during reset SHALL be ignored; the first plot accepted is the one sampled on the first cycle with reset=0.

Structure
REQ-032 Shared package SHALL hold SCREEN_W, SCREEN_H, ADDR_W=15, COLOR_W=3, X_W=8, Y_W=7 and the plot-entry record type {addr, color}.
REQ-033 FIFO SHALL be one sub-module, plot_fifo (synchronous, registered pointers, full/empty flags, simultaneous push/pop); capture, address and counters stay in plot_receiver.

Verification
REQ-034 Single plot x=3,y=2,color=101, mem_ready=1 -> mem_we at N+2, mem_addr=323, mem_data=101, busy low at N+3.
REQ-035 Corner x=159,y=119 -> mem_addr=19199; x=160,y=0 and x=0,y=120 -> no mem_we, overflow=0, dropped_count=0.
REQ-036 mem_ready=0, 12 consecutive plots, FIFO_DEPTH=8 -> 8 stored, dropped_count=4, overflow=1; then mem_ready=1 -> first 8 plots written in order.
REQ-037 FIFO full, writeEn=1 and mem_ready=1 same cycle -> no drop, occupancy stays 8, dropped_count unchanged.
REQ-038 300 overflow drops -> dropped_count saturates at 255; reset mid-drain with 5 pending -> mem_we=0 next cycle, all outputs zero, no stale write after release.
REQ-039 Random writeEn/mem_ready for 10000 cycles -> written sequence equals the accepted in-range plot sequence minus drops, busy=0 after drain.
